// File: rtl/btb_pkg.sv
// btb_pkg: shared definitions for the branch target buffer.
// Holds the geometry of the 2-way BTB, the bit layout of one way entry,
// and the 2-bit saturating counter encodings. Also provides a helper
// that packs a freshly allocated entry.
package btb_pkg;

  localparam int NUM_SETS = 8;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = 27;
  localparam int ENTRY_W  = 64;
  localparam int SET_W    = 2 * ENTRY_W;

  // Entry layout: valid | tag | target | counter | two zero bits
  localparam int VALID_BIT = 63;
  localparam int TAG_HI    = 62;
  localparam int TAG_LO    = 36;
  localparam int TGT_HI    = 35;
  localparam int TGT_LO    = 4;
  localparam int ST_HI     = 3;
  localparam int ST_LO     = 2;

  // Counter states; the predicted direction is the upper bit
  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAK_TAKEN       = 2'b10;
  localparam logic [1:0] STRONG_TAKEN     = 2'b11;

  // Builds a valid entry; the two low bits are always stored as zero
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [TAG_W-1:0] tag,
                                                   input logic [31:0]      target,
                                                   input logic [1:0]       state);
    make_entry = {1'b1, tag, target, state, 2'b00};
  endfunction

endpackage

// File: rtl/btb_update_if.sv
// btb_update_if: branch-resolution update bus from execute into the BTB.
// master (execute side): drives upd_valid/upd_pc/upd_target/upd_taken,
//   receives upd_done/upd_hit/upd_alloc.
// slave (BTB side): the mirror image.
interface btb_update_if;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_done;
  logic        upd_hit;
  logic        upd_alloc;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  upd_done, upd_hit, upd_alloc
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output upd_done, upd_hit, upd_alloc
  );

endinterface

// File: rtl/btb_counter_next.sv
// btb_counter_next: combinational 2-bit saturating counter step.
// Ports: state (current counter), taken (resolved direction),
//        state_next (counter after training).
module btb_counter_next
  import btb_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] state_next
);

  // Move one step toward the resolved direction, holding at either end
  always_comb begin
    state_next = state;
    if (taken) begin
      if (state != STRONG_TAKEN) state_next = state + 2'd1;
    end else begin
      if (state != STRONG_NOT_TAKEN) state_next = state - 2'd1;
    end
  end

endmodule

// File: rtl/btb_update.sv
// btb_update: storage and update stage of the 2-way, 8-set BTB.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous invalidate of the whole BTB
//   rd_index, read_set  fetch read port (combinational, no forwarding)
//   LRU                 per-set most-recently-used way
//   lru_wr_en/index/val fetch-side LRU refresh
//   upd                 update bus (slave): request in, done/hit/alloc out
// Updates go through a request register (stage 1) and a lookup plus
// read-modify-write (stage 2). Stage 2 always reads the array after the
// previous request's write, so back-to-back updates need no bypass.
module btb_update
  import btb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [IDX_W-1:0]    rd_index,
  output logic [SET_W-1:0]    read_set,
  output logic [NUM_SETS-1:0] LRU,
  input  logic                lru_wr_en,
  input  logic [IDX_W-1:0]    lru_wr_index,
  input  logic                lru_wr_val,
  btb_update_if.slave         upd
);

  logic [SET_W-1:0]    sets_q [NUM_SETS];
  logic [SET_W-1:0]    sets_d [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q, lru_d;

  logic        s1_valid_q, s1_valid_d;
  logic [31:2] s1_pc_q, s1_pc_d;
  logic [31:0] s1_target_q, s1_target_d;
  logic        s1_taken_q, s1_taken_d;

  logic done_q, done_d;
  logic hit_q, hit_d;
  logic alloc_q, alloc_d;

  logic [IDX_W-1:0]   s2_index;
  logic [TAG_W-1:0]   s2_tag;
  logic [ENTRY_W-1:0] way0, way1, new_entry;
  logic               hit0, hit1, hit_way, victim;
  logic [1:0]         hit_state, hit_state_next;
  logic               unused_pc_bits;

  // Byte offset bits of the branch PC play no part in index or tag
  assign unused_pc_bits = ^upd.upd_pc[1:0];

  assign s2_index = s1_pc_q[4:2];
  assign s2_tag   = s1_pc_q[31:5];
  assign way0     = sets_q[s2_index][SET_W-1:ENTRY_W];
  assign way1     = sets_q[s2_index][ENTRY_W-1:0];
  assign hit0     = way0[VALID_BIT] && (way0[TAG_HI:TAG_LO] == s2_tag);
  assign hit1     = way1[VALID_BIT] && (way1[TAG_HI:TAG_LO] == s2_tag);
  // Way0 wins when both ways carry the same tag
  assign hit_way   = hit0 ? 1'b0 : 1'b1;
  assign hit_state = hit_way ? way1[ST_HI:ST_LO] : way0[ST_HI:ST_LO];
  // Fill an empty way first; only evict the least-recently-used way when full
  assign victim = !way0[VALID_BIT] ? 1'b0 :
                  !way1[VALID_BIT] ? 1'b1 : ~lru_q[s2_index];

  btb_counter_next u_counter_next (
    .state      (hit_state),
    .taken      (s1_taken_q),
    .state_next (hit_state_next)
  );

  // Next-state logic: capture the request, apply the fetch LRU refresh,
  // then let stage 2 overwrite (so its LRU write wins on the same set),
  // and finally let flush override everything.
  always_comb begin
    sets_d      = sets_q;
    lru_d       = lru_q;
    new_entry   = '0;
    s1_valid_d  = upd.upd_valid & ~flush;
    s1_pc_d     = upd.upd_pc[31:2];
    s1_target_d = upd.upd_target;
    s1_taken_d  = upd.upd_taken;
    done_d      = 1'b0;
    hit_d       = 1'b0;
    alloc_d     = 1'b0;

    if (lru_wr_en) lru_d[lru_wr_index] = lru_wr_val;

    if (s1_valid_q) begin
      done_d = 1'b1;
      if (hit0 || hit1) begin
        new_entry              = hit_way ? way1 : way0;
        new_entry[ST_HI:ST_LO] = hit_state_next;
        new_entry[1:0]         = 2'b00;
        if (s1_taken_q) new_entry[TGT_HI:TGT_LO] = s1_target_q;
        if (hit_way) sets_d[s2_index][ENTRY_W-1:0]     = new_entry;
        else         sets_d[s2_index][SET_W-1:ENTRY_W] = new_entry;
        lru_d[s2_index] = hit_way;
        hit_d           = 1'b1;
      end else if (s1_taken_q) begin
        new_entry = make_entry(s2_tag, s1_target_q, WEAK_TAKEN);
        if (victim) sets_d[s2_index][ENTRY_W-1:0]     = new_entry;
        else        sets_d[s2_index][SET_W-1:ENTRY_W] = new_entry;
        lru_d[s2_index] = victim;
        alloc_d         = 1'b1;
      end
    end

    if (flush) begin
      for (int i = 0; i < NUM_SETS; i++) sets_d[i] = '0;
      lru_d   = '0;
      done_d  = 1'b0;
      hit_d   = 1'b0;
      alloc_d = 1'b0;
    end
  end

  // State registers; reset drops the array and any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) sets_q[i] <= '0;
      lru_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pc_q     <= '0;
      s1_target_q <= '0;
      s1_taken_q  <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      alloc_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SETS; i++) sets_q[i] <= sets_d[i];
      lru_q       <= lru_d;
      s1_valid_q  <= s1_valid_d;
      s1_pc_q     <= s1_pc_d;
      s1_target_q <= s1_target_d;
      s1_taken_q  <= s1_taken_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      alloc_q     <= alloc_d;
    end
  end

  assign read_set      = sets_q[rd_index];
  assign LRU           = lru_q;
  assign upd.upd_done  = done_q;
  assign upd.upd_hit   = hit_q;
  assign upd.upd_alloc = alloc_q;

endmodule

// File: tb/tb_btb_update.sv
// tb_btb_update: scoreboard bench for btb_update.
// A reference model of the BTB (per-way fields plus LRU bits) is updated
// by the driver at every clock edge; expected done/hit/alloc results are
// queued with the edge after which they must appear, and a monitor on the
// falling edge compares outputs and the read port against the model.
module tb_btb_update;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [2:0]   rd_index;
  logic [127:0] read_set;
  logic [7:0]   LRU;
  logic         lru_wr_en;
  logic [2:0]   lru_wr_index;
  logic         lru_wr_val;

  btb_update_if bus ();

  btb_update dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rd_index     (rd_index),
    .read_set     (read_set),
    .LRU          (LRU),
    .lru_wr_en    (lru_wr_en),
    .lru_wr_index (lru_wr_index),
    .lru_wr_val   (lru_wr_val),
    .upd          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_num = 0;
  bit running = 0;

  // Reference model
  bit          m_valid [8][2];
  logic [26:0] m_tag   [8][2];
  logic [31:0] m_tgt   [8][2];
  int          m_st    [8][2];
  bit [7:0]    m_lru;

  bit          pend_v;
  logic [31:0] pend_pc, pend_tgt;
  bit          pend_tk;

  typedef struct {
    int due;
    bit hit;
    bit alloc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_tag[s][w]   = '0;
        m_tgt[s][w]   = '0;
        m_st[s][w]    = 0;
      end
    m_lru = '0;
  endfunction

  function automatic logic [127:0] model_set(input int s);
    logic [63:0] e [2];
    for (int w = 0; w < 2; w++) begin
      logic [1:0] st2;
      st2 = m_st[s][w][1:0];
      e[w] = m_valid[s][w] ? {1'b1, m_tag[s][w], m_tgt[s][w], st2, 2'b00} : 64'd0;
    end
    return {e[0], e[1]};
  endfunction

  // Resolves one branch against the model and reports hit/alloc
  function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                       input bit tk, output bit hit, output bit alloc);
    int s, w, v;
    s = int'(pc[4:2]);
    w = -1;
    hit = 0;
    alloc = 0;
    for (int k = 0; k < 2; k++)
      if (w < 0 && m_valid[s][k] && m_tag[s][k] == pc[31:5]) w = k;
    if (w >= 0) begin
      if (tk) m_st[s][w] = (m_st[s][w] == 3) ? 3 : m_st[s][w] + 1;
      else    m_st[s][w] = (m_st[s][w] == 0) ? 0 : m_st[s][w] - 1;
      if (tk) m_tgt[s][w] = tgt;
      m_lru[s] = (w == 1);
      hit = 1;
    end else if (tk) begin
      if (!m_valid[s][0])      v = 0;
      else if (!m_valid[s][1]) v = 1;
      else                     v = m_lru[s] ? 0 : 1;
      m_valid[s][v] = 1;
      m_tag[s][v]   = pc[31:5];
      m_tgt[s][v]   = tgt;
      m_st[s][v]    = 2;
      m_lru[s]      = (v == 1);
      alloc = 1;
    end
  endfunction

  // Drives one cycle of inputs and advances the model across the edge
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                               input bit tk, input bit le, input logic [2:0] li, input bit lv,
                               input bit fl, input bit rs, input logic [2:0] ri);
    bit h, a;
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
    lru_wr_en      = le;
    lru_wr_index   = li;
    lru_wr_val     = lv;
    flush          = fl;
    rd_index       = ri;
    if (rs) begin
      rst_n = 1'b0;
      model_clear();
      pend_v = 0;
      sb_q.delete();
    end else begin
      rst_n = 1'b1;
    end
    @(posedge clk);
    edge_num++;
    if (!rs) begin
      if (fl) begin
        model_clear();
        pend_v = 0;
      end else begin
        if (le) m_lru[li] = lv;
        if (pend_v) begin
          model_update(pend_pc, pend_tgt, pend_tk, h, a);
          sb_q.push_back('{edge_num, h, a});
        end
        pend_v   = v;
        pend_pc  = pc;
        pend_tgt = tgt;
        pend_tk  = tk;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [2:0] ri);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 3'd0, 0, 0, 0, ri);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    applyStimulus(1, pc, tgt, tk, 0, 3'd0, 0, 0, 0, pc[4:2]);
  endtask

  // Monitor: read port and LRU against the model, done/hit/alloc against the queue
  always @(negedge clk) begin
    if (running) begin
      bit exp_done;
      checkOutput("read_set", read_set, model_set(int'(rd_index)));
      checkOutput("LRU", LRU, m_lru);
      exp_done = (sb_q.size() != 0) && (sb_q[0].due == edge_num);
      checkOutput("upd_done", bus.upd_done, exp_done);
      if (exp_done) begin
        mon_e = sb_q.pop_front();
        if (bus.upd_done) begin
          checkOutput("upd_hit", bus.upd_hit, mon_e.hit);
          checkOutput("upd_alloc", bus.upd_alloc, mon_e.alloc);
        end
      end else begin
        checkOutput("upd_hit_idle", bus.upd_hit, 1'b0);
        checkOutput("upd_alloc_idle", bus.upd_alloc, 1'b0);
      end
    end
  end

  initial begin
    logic [1:0]  exp_st [6];
    bit          tk_seq [6];
    logic [26:0] tag;
    logic [31:0] pc;
    int          r;

    rst_n = 1'b0;
    flush = 1'b0;
    rd_index = '0;
    lru_wr_en = 1'b0;
    lru_wr_index = '0;
    lru_wr_val = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    bus.upd_taken = 1'b0;
    model_clear();
    pend_v = 0;
    running = 1;

    // Reset and sweep the read port
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      checkOutput("reset_read_set", read_set, 128'd0);
      checkOutput("reset_LRU", LRU, 8'd0);
      checkOutput("reset_done", bus.upd_done, 1'b0);
    end

    // First allocation into set 1, way0
    update(32'h0000_1004, 32'h0000_2000, 1);
    idle(3'd1);
    checkOutput("alloc_way0", read_set[127:64], {1'b1, 27'h80, 32'h2000, 2'b10, 2'b00});
    checkOutput("alloc_done", bus.upd_done, 1'b1);
    checkOutput("alloc_flag", bus.upd_alloc, 1'b1);
    checkOutput("alloc_lru1", LRU[1], 1'b0);

    // Counter training, back to back; not-taken updates keep the target
    tk_seq = '{1, 1, 0, 0, 0, 0};
    exp_st = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int j = 0; j <= 6; j++) begin
      if (j < 6) update(32'h0000_1004, tk_seq[j] ? 32'h0000_2000 : 32'h0000_9990, tk_seq[j]);
      else idle(3'd1);
      if (j > 0) begin
        checkOutput("counter_state", read_set[67:66], exp_st[j-1]);
        checkOutput("counter_target", read_set[99:68], 32'h2000);
      end
    end

    // Fill set 1, refresh LRU toward way0, then evict way1
    update(32'h0000_1004, 32'h0000_2000, 1);
    update(32'h0000_2004, 32'h0000_3000, 1);
    idle(3'd1);
    applyStimulus(0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 3'd1);
    update(32'h0000_3004, 32'h0000_4000, 1);
    idle(3'd1);
    checkOutput("evict_way1_tag", read_set[62:36], 27'h180);
    checkOutput("evict_way0_tag", read_set[126:100], 27'h80);
    checkOutput("evict_lru1", LRU[1], 1'b1);

    // Same-set fetch refresh and stage-2 LRU write: stage 2 wins
    update(32'h0000_1004, 32'h0000_2000, 1);
    applyStimulus(0, 0, 0, 0, 1, 3'd1, 1, 0, 0, 3'd1);
    checkOutput("lru_conflict", LRU[1], 1'b0);

    // Flush drops the in-flight request and clears everything
    update(32'h0000_5008, 32'h0000_6000, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2);
    checkOutput("flush_no_done", bus.upd_done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      checkOutput("flush_read_set", read_set, 128'd0);
      checkOutput("flush_LRU", LRU, 8'd0);
    end

    // Randomized traffic with a small tag pool so hits and evictions occur
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 4))
        0: tag = 27'h80;
        1: tag = 27'h100;
        2: tag = 27'h180;
        3: tag = 27'h200;
        default: tag = 27'($urandom);
      endcase
      pc = {tag, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      applyStimulus($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    r < 4, r == 199, 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 4; i++) idle(3'(i));
    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
